// File: rtl/rv_width_downsizer_pkg.sv
// Shared types and helpers for the ready/valid width down-converter.
// Holds state encodings, clog2 and the RATIO legality check.
package rv_width_downsizer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   localparam int RATIO_MIN = 2;
   localparam int RATIO_MAX = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic bit ratio_ok(input int r);
      return (r >= RATIO_MIN) && (r <= RATIO_MAX);
   endfunction

endpackage

// File: rtl/rv_width_downsizer_beat_counter.sv
// Beat index / beat count tracker for the down-converter.
// Loads a clamped count, advances per beat, flags the final beat.
module rv_beat_counter
   import rv_width_downsizer_pkg::*;
#(
   parameter int RATIO = 4
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       load,
   input  logic [clog2(RATIO+1)-1:0]  cnt,
   input  logic                       step,
   input  logic                       done,
   output logic [clog2(RATIO)-1:0]    idx,
   output logic                       last
);

   localparam int CW = clog2(RATIO + 1);

   logic [CW-1:0] n;
   logic [CW-1:0] n_ld;

   assign n_ld = (cnt > CW'(RATIO)) ? CW'(RATIO) : cnt;

   always_ff @(posedge clk) begin
      if (arst) begin
         idx  <= '0;
         n    <= '0;
         last <= 1'b0;
      end else if (load) begin
         idx  <= '0;
         n    <= n_ld;
         last <= (n_ld == CW'(1));
      end else if (step) begin
         idx  <= idx + 1'b1;
         last <= ((CW'(idx) + CW'(1)) == (n - CW'(1)));
      end else if (done) begin
         last <= 1'b0;
      end
   end

endmodule

// File: rtl/rv_width_downsizer.sv
// Ready/valid width down-converter: one wide word in, up to RATIO
// narrow beats out, LSB sub-word first, last beat flagged.
module rv_width_downsizer
   import rv_width_downsizer_pkg::*;
#(
   parameter int WIDTH_OUT = 16,
   parameter int RATIO     = 4,
   localparam int CW       = clog2(RATIO + 1)
) (
   input  logic                       clk,
   input  logic                       arst,
   input  logic                       valid_i,
   input  logic [RATIO*WIDTH_OUT-1:0] dat_i,
   input  logic [CW-1:0]              cnt_i,
   output logic                       ready_i,
   output logic                       valid_o,
   output logic [WIDTH_OUT-1:0]       dat_o,
   output logic                       last_o,
   input  logic                       ready_o
);

   localparam int IW = clog2(RATIO);

   if (!ratio_ok(RATIO)) begin : g_ratio_chk
      $error("rv_width_downsizer: RATIO must be in 2..16");
   end

   state_t               state;
   logic [WIDTH_OUT-1:0] hold [RATIO];
   logic [IW-1:0]        idx;
   logic                 in_xfer;
   logic                 out_xfer;
   logic                 load;
   logic                 step;
   logic                 done;

   // Combinational path from ready_o keeps consecutive words bubble-free.
   assign ready_i  = !arst & (!valid_o | (ready_o & last_o));
   assign valid_o  = (state == SHIFT);
   assign in_xfer  = valid_i & ready_i;
   assign out_xfer = valid_o & ready_o;
   assign load     = in_xfer & (cnt_i != '0);
   assign step     = out_xfer & !last_o;
   assign done     = out_xfer & last_o & !load;

   rv_beat_counter #(
      .RATIO (RATIO)
   ) u_cnt (
      .clk  (clk),
      .arst (arst),
      .load (load),
      .cnt  (cnt_i),
      .step (step),
      .done (done),
      .idx  (idx),
      .last (last_o)
   );

   always_ff @(posedge clk) begin
      if (arst) begin
         state <= IDLE;
         dat_o <= '0;
         for (int k = 0; k < RATIO; k++) hold[k] <= '0;
      end else if (load) begin
         state <= SHIFT;
         dat_o <= dat_i[WIDTH_OUT-1:0];
         for (int k = 0; k < RATIO; k++)
            hold[k] <= dat_i[k*WIDTH_OUT +: WIDTH_OUT];
      end else if (step) begin
         dat_o <= hold[idx + 1'b1];
      end else if (done) begin
         state <= IDLE;
      end
   end

endmodule
